// File: rtl/shift_pkg.sv
// Shared types and widths for the shift scheduler and its shifter3 engine.
package shift_pkg;

    localparam int SHIFT_WIDTH = 32;
    localparam int SHIFT_WSHAM = $clog2(SHIFT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [SHIFT_WIDTH-1:0] val;
        logic [SHIFT_WSHAM-1:0] sham;
        logic                   right;
        logic                   arith;
        logic                   id;
    } shift_op_t;

endpackage

// File: rtl/shifter3.sv
// Multicycle shift engine: up to 3 bit positions per cycle, no operand storage.
// Right shifts by a nonzero amount spend their start cycle on setup before stepping.
module shifter3 #(
    parameter int  WIDTH = 32,
    localparam int WSHAM = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] val_i,
    input  logic [WSHAM-1:0] sham_i,
    input  logic             right_shift,
    input  logic             arith_shift,
    output logic [WIDTH-1:0] val_o,
    output logic [WSHAM-1:0] sham_o,
    output logic             done
);

    logic             run_q;
    logic             run_d;
    logic             active;
    logic             step;
    logic [WSHAM-1:0] amt;

    always_comb begin
        active = start | run_q;
        step   = run_q | ~right_shift | (sham_i == '0);
        amt    = '0;
        if (step) begin
            amt = (sham_i > WSHAM'(3)) ? WSHAM'(3) : sham_i;
        end
        if (!right_shift) begin
            val_o = val_i << amt;
        end else if (arith_shift) begin
            val_o = $unsigned($signed(val_i) >>> amt);
        end else begin
            val_o = val_i >> amt;
        end
        sham_o = sham_i - amt;
        done   = active & step & (sham_i <= WSHAM'(3));
        run_d  = active & ~done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/shift_sched.sv
// Round-robin two-requester scheduler driving the shared shifter3 engine.
// Optional SHIFT_SCHED_BYPASS_EN: zero-amount requests skip RUN and respond next cycle.
module shift_sched
    import shift_pkg::*;
#(
    parameter int  WIDTH = SHIFT_WIDTH,
    localparam int WSHAM = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][WIDTH-1:0] req_val,
    input  logic [1:0][WSHAM-1:0] req_sham,
    input  logic [1:0]            req_right,
    input  logic [1:0]            req_arith,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_id,
    output logic                  busy
);

    sched_state_e     state_q, state_d;
    shift_op_t        op_q, op_d;
    logic [1:0]       ptr_q, ptr_d;
    logic             start_q, start_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_id_q, rsp_id_d;

    logic [1:0]       grant;
    logic             sel;
    logic [WIDTH-1:0] eng_val;
    logic [WSHAM-1:0] eng_sham;
    logic             eng_done;

    shifter3 #(.WIDTH(WIDTH)) u_engine (
        .clk         (clk),
        .rst         (rst),
        .start       (start_q),
        .val_i       (op_q.val),
        .sham_i      (op_q.sham),
        .right_shift (op_q.right),
        .arith_shift (op_q.arith),
        .val_o       (eng_val),
        .sham_o      (eng_sham),
        .done        (eng_done)
    );

    always_comb begin
        // ptr_q is one-hot and names the requester that wins a tie
        grant = 2'b00;
        if (state_q == IDLE) begin
            grant = (req_valid == 2'b11) ? ptr_q : req_valid;
        end
        sel = grant[1];

        state_d     = state_q;
        op_d        = op_q;
        ptr_d       = ptr_q;
        start_d     = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;

        case (state_q)
            IDLE: begin
                if (|grant) begin
                    op_d = '{val: req_val[sel], sham: req_sham[sel], right: req_right[sel],
                             arith: req_arith[sel], id: sel};
                    ptr_d   = ~grant;
                    state_d = RUN;
                    start_d = 1'b1;
`ifdef SHIFT_SCHED_BYPASS_EN
                    if (req_sham[sel] == '0) begin
                        state_d     = RESP;
                        start_d     = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = req_val[sel];
                        rsp_id_d    = sel;
                    end
`endif
                end
            end
            RUN: begin
                op_d.val  = eng_val;
                op_d.sham = eng_sham;
                if (eng_done) begin
                    rsp_data_d  = eng_val;
                    rsp_id_d    = op_q.id;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        op_q <= op_d;
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 2'b01;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule
